// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI arbiter, master and slave.
package spi_pkg;
  localparam int SPI_W = 8;
  localparam logic [SPI_W-1:0] CMD_WRITE = 8'h02;
  localparam logic [SPI_W-1:0] CMD_READ  = 8'h03;
  localparam logic [SPI_W-1:0] CMD_RDSR  = 8'h05;
  localparam logic [SPI_W-1:0] CMD_WREN  = 8'h06;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_END, DONE} arb_state_e;
endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, search starts just after last_i.
module rr_pick #(
  parameter int N = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  win_o,
  output logic [LW-1:0] idx_o
);
  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N]) begin
        win_o = '0;
        win_o[(int'(last_i) + k) % N] = 1'b1;
        idx_o = LW'((int'(last_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master among NUM_REQ requesters.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int START_TIMEOUT = 16,
  parameter int END_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [SPI_W*NUM_REQ-1:0] req_cmd,
  input  logic [SPI_W*NUM_REQ-1:0] req_addr,
  input  logic [SPI_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [SPI_W-1:0]         rdata,
  output logic                     spi_en,
  output logic [SPI_W-1:0]         spi_cmd,
  output logic [SPI_W-1:0]         spi_addr,
  output logic [SPI_W-1:0]         spi_wdata,
  input  logic                     spi_cs,
  input  logic [SPI_W-1:0]         spi_rdata
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int TW = $clog2(END_TIMEOUT + 1);
  arb_state_e state_q;
  logic [NUM_REQ-1:0] gnt_q, done_q, pick_oh;
  logic [LW-1:0] last_q, win_q, pick_idx;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SPI_W-1:0] rdata_q, cmd_q, addr_q, wdata_q;
  logic err_q, spi_en_q;
  rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
    .req_i (req),
    .last_i(last_q),
    .win_o (pick_oh),
    .idx_o (pick_idx)
  );
  assign tmr_d = &tmr_q ? tmr_q : tmr_q + 1'b1;
  // Timeouts fire on the edge where the counter would reach its limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      spi_en_q <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= LW'(NUM_REQ - 1);
      win_q    <= '0;
      tmr_q    <= '0;
    end else begin
      spi_en_q <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          gnt_q    <= pick_oh;
          win_q    <= pick_idx;
          cmd_q    <= req_cmd[pick_idx*SPI_W +: SPI_W];
          addr_q   <= req_addr[pick_idx*SPI_W +: SPI_W];
          wdata_q  <= req_wdata[pick_idx*SPI_W +: SPI_W];
          spi_en_q <= 1'b1;
          state_q  <= LAUNCH;
        end
        LAUNCH: begin
          tmr_q   <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: if (!spi_cs) begin
          tmr_q   <= '0;
          state_q <= WAIT_END;
        end else if (tmr_d == TW'(START_TIMEOUT)) begin
          done_q  <= gnt_q;
          err_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          tmr_q <= tmr_d;
        end
        WAIT_END: if (spi_cs) begin
          rdata_q <= spi_rdata;
          done_q  <= gnt_q;
          state_q <= DONE;
        end else if (tmr_d == TW'(END_TIMEOUT)) begin
          done_q  <= gnt_q;
          err_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          tmr_q <= tmr_d;
        end
        DONE: begin
          last_q  <= win_q;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign spi_en    = spi_en_q;
  assign spi_cmd   = cmd_q;
  assign spi_addr  = addr_q;
  assign spi_wdata = wdata_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural SPI master/memory model.
module tb_spi_arbiter;
  import spi_pkg::*;
  localparam int N = 4, ST = 16, ET = 1024, CS_LEN = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_cmd = '0, req_addr = '0, req_wdata = '0;
  logic [N-1:0] gnt, done;
  logic err, spi_en, spi_cs;
  logic [7:0] rdata, spi_cmd, spi_addr, spi_wdata, spi_rdata;
  spi_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST), .END_TIMEOUT(ET)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .spi_en(spi_en), .spi_cmd(spi_cmd), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_cs(spi_cs), .spi_rdata(spi_rdata)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [1:0] idx; logic err; logic [7:0] rdata; logic [7:0] cmd;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, en_cnt = 0, mode = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Master model: mode 0 normal, 1 never lowers cs, 2 holds cs low forever.
  logic busy;
  int cnt;
  logic [7:0] m_cmd, m_addr, m_wd;
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      spi_cs <= 1'b1; busy <= 1'b0; cnt <= 0; spi_rdata <= '0;
    end else if (!busy) begin
      if (spi_en && mode != 1) begin
        busy <= 1'b1; cnt <= 0; spi_cs <= 1'b0;
        m_cmd <= spi_cmd; m_addr <= spi_addr; m_wd <= spi_wdata;
      end
    end else if (mode != 2 && cnt >= CS_LEN - 1) begin
      busy <= 1'b0; spi_cs <= 1'b1;
      if (m_cmd == CMD_READ) spi_rdata <= mem[m_addr];
      else begin
        spi_rdata <= '0;
        if (m_cmd == CMD_WRITE) mem[m_addr] <= m_wd;
      end
    end else cnt <= cnt + 1;
  end
  always @(negedge clk) if (!rst && spi_en === 1'b1) en_cnt++;
  always @(negedge clk) begin
    if (!rst && done !== '0) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: got %0h expected none", done);
      end else begin
        e = q.pop_front();
        chk("done_onehot", done, 4'(1) << e.idx);
        chk("done_err", err, e.err);
        chk("done_rdata", rdata, e.rdata);
        chk("done_cmd", spi_cmd, e.cmd);
      end
    end
  end
  task automatic set_req(int i, logic [7:0] c, logic [7:0] a, logic [7:0] w);
    req_cmd[i*8 +: 8] = c; req_addr[i*8 +: 8] = a; req_wdata[i*8 +: 8] = w;
  endtask
  task automatic push(int i, logic er, logic [7:0] rd, logic [7:0] c);
    exp_t x;
    x.idx = 2'(i); x.err = er; x.rdata = rd; x.cmd = c;
    q.push_back(x);
  endtask
  task automatic wait_launch(output logic [N-1:0] g, output int cyc);
    bit ok = 0;
    g = '0; cyc = 0;
    while (!ok && cyc < 3000) begin
      @(negedge clk); cyc++;
      ok = (spi_en === 1'b1);
    end
    if (ok) g = gnt;
    else begin checks++; failures++; $display("FAIL launch_timeout: got none expected spi_en"); end
  endtask
  task automatic wait_done(output int cyc);
    bit ok = 0;
    cyc = 0;
    while (!ok && cyc < 3000) begin
      @(negedge clk); cyc++;
      ok = (done !== '0);
    end
    if (!ok) begin checks++; failures++; $display("FAIL done_timeout: got none expected done"); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [N-1:0] g;
    int c;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0); chk("rst_en", spi_en, 0); chk("rst_cmd", spi_cmd, 0);
    chk("rst_addr", spi_addr, 0); chk("rst_wdata", spi_wdata, 0);
    // Contention: all four held for five grants.
    for (int i = 0; i < N; i++) set_req(i, CMD_WRITE, 8'h20 + 8'(i), 8'h30 + 8'(i));
    for (int k = 0; k < 5; k++) push(k % N, 1'b0, 8'h00, CMD_WRITE);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_launch(g, c);
      chk("rr_order", g, 4'(1) << (k % N));
      if (k > 0) chk("rr_gap", c, 7);
    end
    req = '0;
    wait_done(c);
    repeat (2) @(negedge clk);
    // Fairness: serve 1, then 0011 must go to 0 first.
    set_req(1, CMD_WRITE, 8'h50, 8'h66); push(1, 1'b0, 8'h00, CMD_WRITE);
    req = 4'b0010; wait_launch(g, c); req = '0; wait_done(c);
    repeat (2) @(negedge clk);
    set_req(0, CMD_WRITE, 8'h51, 8'h77);
    push(0, 1'b0, 8'h00, CMD_WRITE); push(1, 1'b0, 8'h00, CMD_WRITE);
    req = 4'b0011;
    wait_launch(g, c); chk("fair_first", g, 4'b0001); req[0] = 1'b0;
    wait_launch(g, c); chk("fair_second", g, 4'b0010); req[1] = 1'b0;
    wait_done(c);
    repeat (2) @(negedge clk);
    // Single write then read back, with launch latency.
    set_req(0, CMD_WRITE, 8'h10, 8'hA5); push(0, 1'b0, 8'h00, CMD_WRITE);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("lat_gnt", gnt, 4'b0001); chk("lat_en", spi_en, 1);
    req = '0;
    wait_done(c);
    repeat (2) @(negedge clk);
    set_req(0, CMD_READ, 8'h10, 8'h00); push(0, 1'b0, 8'hA5, CMD_READ);
    req = 4'b0001; wait_launch(g, c); req = '0; wait_done(c);
    repeat (2) @(negedge clk);
    // Start timeout: cs never falls.
    mode = 1;
    set_req(2, CMD_WRITE, 8'h40, 8'h11); push(2, 1'b1, 8'hA5, CMD_WRITE);
    req = 4'b0100; wait_launch(g, c); chk("sto_gnt", g, 4'b0100); req = '0;
    wait_done(c); chk("sto_latency", c, ST + 1);
    mode = 0;
    repeat (2) @(negedge clk);
    // End timeout: cs stuck low.
    mode = 2;
    set_req(1, CMD_READ, 8'h10, 8'h00); push(1, 1'b1, 8'hA5, CMD_READ);
    req = 4'b0010; wait_launch(g, c); req = '0;
    wait_done(c); chk("eto_latency", c, ET + 2);
    mode = 0;
    repeat (3) @(negedge clk);
    // Request dropped right after grant.
    set_req(3, CMD_READ, 8'h10, 8'h00); push(3, 1'b0, 8'hA5, CMD_READ);
    req = 4'b1000; wait_launch(g, c); chk("drop_gnt", g, 4'b1000); req = '0;
    wait_done(c);
    repeat (2) @(negedge clk);
    // Reset during WAIT_END.
    mode = 2;
    set_req(0, CMD_READ, 8'h10, 8'h00);
    req = 4'b0001; wait_launch(g, c); req = '0;
    repeat (4) @(negedge clk);
    chk("mid_state", dut.state_q, WAIT_END);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_gnt", gnt, 0); chk("mr_done", done, 0); chk("mr_err", err, 0);
    chk("mr_rdata", rdata, 0); chk("mr_en", spi_en, 0); chk("mr_cmd", spi_cmd, 0);
    chk("mr_state", dut.state_q, IDLE);
    rst = 1'b0; mode = 0;
    set_req(2, CMD_WRITE, 8'h60, 8'h99); push(2, 1'b0, 8'h00, CMD_WRITE);
    req = 4'b0100;
    @(posedge clk); #1;
    chk("post_rst_gnt", gnt, 4'b0100);
    req = '0;
    wait_done(c);
    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    chk("en_total", en_cnt, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one `spi_master` among `NUM_REQ` independent requesters. It sits between client logic and the master's `en` / `ext_*` command port. It latches one requester's command, address and write data, launches a single SPI transaction, and tracks it to completion via the master's chip-select. It then returns read data and a completion or error pulse to the granted requester.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `START_TIMEOUT`, 16 — cycles allowed from `spi_en` until `spi_cs` falls.
- `END_TIMEOUT`, 1024 — cycles allowed with `spi_cs` low before abort.

Ports:
- `clk`  in  1  — single clock for the whole block.
- `rst`  in  1  — reset, synchronous, active-high.
- `req`  in  NUM_REQ  — per-requester transaction request (level).
- `req_cmd`  in  8*NUM_REQ  — packed commands; slice i is requester i.
- `req_addr`  in  8*NUM_REQ  — packed addresses.
- `req_wdata`  in  8*NUM_REQ  — packed write data.
- `gnt`  out  NUM_REQ  — one-hot grant, held from LAUNCH through DONE.
- `done`  out  NUM_REQ  — one-cycle completion pulse to the granted requester.
- `err`  out  1  — valid with `done`; 1 = timeout abort.
- `rdata`  out  8  — read data, valid in the `done` cycle, held until the next `done`.
- `spi_en`  out  1  — to master `en`.
- `spi_cmd`, `spi_addr`, `spi_wdata`  out  8 each  — to master `ext_command_in` / `ext_address_in` / `ext_data_in`.
- `spi_cs`  in  1  — master chip-select, active-low.
- `spi_rdata`  in  8  — master `ext_data_out`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_END, DONE.
- IDLE
  - If any `req` bit is set, pick the winner round-robin: search starts at `last+1` mod NUM_REQ, where `last` is the previous winner (reset value NUM_REQ-1, so requester 0 wins first).
  - Register the winner's cmd/addr/wdata into `spi_cmd/addr/wdata`. Go to LAUNCH.
- LAUNCH
  - `spi_en` = 1 for exactly this cycle. `gnt` is one-hot. Timer cleared. Go to WAIT_START.
- WAIT_START
  - `spi_cs` = 0 → WAIT_END with timer cleared.
  - Timer reaches START_TIMEOUT → DONE with error set.
- WAIT_END
  - `spi_cs` = 1 → DONE: capture `spi_rdata` into `rdata`, error cleared.
  - Timer reaches END_TIMEOUT → DONE with error set; `rdata` is unchanged.
- DONE
  - `done[winner]` = 1 and `err` is driven. Update `last` = winner. Go to IDLE.
- Payload is latched at grant. Requesters may change `req_*` after `gnt`.
- Dropping `req` mid-transaction is ignored; the transaction completes and `done` still pulses.
- A requester that keeps `req` high gets back-to-back service only when no other bit is set.
- The timer is a counter sized `$clog2(END_TIMEOUT+1)` and saturates.

## Timing
- Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0, `spi_en`=0, `spi_cmd/addr/wdata`=0, state IDLE, `last`=NUM_REQ-1.
- Reset mid-transaction forces the reset values on the next edge. No `done` is issued. The master shares `rst`.
- Latency: `req` sampled in IDLE at cycle t → `gnt` and `spi_en` at t+1. Earliest `spi_cs` fall is observed at t+2.
- Completion: `spi_cs` rise observed at cycle c → `done` and `rdata` at c+1. The next grant is at c+3 at the earliest (DONE → IDLE → LAUNCH).
- `spi_cmd/addr/wdata` are stable from LAUNCH through DONE.
- Simultaneous requests in one IDLE cycle: only the round-robin winner is granted. Others wait; no request is lost while it is held.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum;
  - the 8-bit field width constant `SPI_W`;
  - command opcode constants shared with `spi_master` / `spi_slave`.
- One sub-module, `rr_pick`: a combinational round-robin priority encoder taking `req` and `last` and producing a one-hot winner and its index. The arbiter instantiates it once.

## Test plan
- Single request: `req`=0001 with cmd=0x02, addr=0x10, wdata=0xA5, then a read at addr 0x10 → `spi_en` pulses once per transaction; the read `done[0]` carries `rdata`=0xA5, `err`=0.
- Contention: `req`=1111 held for 4 transactions → grant order 0,1,2,3, then 0 again. Each `done` goes only to its winner.
- Fairness after service: `last`=1, `req`=0011 → grant to requester 0, not 1.
- Start timeout: `spi_cs` forced high after LAUNCH → `done` with `err`=1 exactly START_TIMEOUT+1 cycles after `spi_en`; `rdata` is unchanged.
- Reset mid-op: assert `rst` during WAIT_END → next cycle all outputs are 0 and state is IDLE. A new `req`=0100 is then granted at t+1 to requester 2... first winner after reset is requester 0 only if bit 0 is set.
- Request drop: `req[3]` deasserted the cycle after `gnt[3]` → the transaction completes and `done[3]` still pulses.
